regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Write-port controller for the 32-entry RISC-V register file. It owns the file's single write port (write_en / write_addr / write_data). After reset it sequences a zero-fill of all 32 registers. It then shares the port between two writeback requesters, ALU and load unit, through valid/ready handshakes, one-entry buffers and oldest-first arbitration. It sits between the execute/memory writeback stages and register_file.

## Interface
Parameters:
- WORDSIZE, 64, data width; must match register_file.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted when alu_valid & alu_ready at an edge.
- alu_addr  in  5  ALU destination register.
- alu_data  in  WORDSIZE  ALU result.
- mem_valid / mem_ready / mem_addr / mem_data  same as alu_* for the load unit.
- init_done  out  1  high once the zero-fill is complete.
- write_en  out  1  registered; to register_file write_en.
- write_addr  out  5  registered; to register_file write_addr.
- write_data  out  WORDSIZE  registered; to register_file write_data.

## Operation
- States: INIT, RUN.
  - rst forces INIT with sweep counter = 0.
  - INIT → RUN after the write of address 31 is issued.
  - There is no other exit from RUN except rst.
- INIT: one output write per cycle of (addr = counter, data = 0), counter 0..31. Both ready signals are 0 and init_done is 0.
- RUN: init_done = 1.
- Each requester owns a one-entry slot holding full, addr, data and an age stamp.
- Acceptance:
  - ready = !full | granted_this_cycle, so a same-cycle refill is allowed.
  - ready must not depend on the requester's own valid.
  - An accepted request with addr = 0 is consumed and discarded: it never fills the slot and never produces a write.
- Arbitration (combinational over the slots):
  - One slot full: grant it.
  - Both full: grant the older by acceptance cycle.
  - Both accepted in the same cycle: grant opposite to the last-grant pointer, then update the pointer.
- Grant effect: the slot empties, and the output registers load (1, addr, data) at the same edge.
- No grant in RUN: write_en <= 0. write_addr and write_data keep their previous values.
- Ordering: oldest-first keeps program order between requesters whenever acceptance order matches program order. Upstream guarantees this.

## Timing
- Reset values (after the rst edge): write_en = 0, write_addr = 0, write_data = 0, alu_ready = 0, mem_ready = 0, init_done = 0, slots empty, pointer = ALU.
- rst asserted mid-operation (INIT or RUN):
  - Buffered requests are discarded.
  - The sweep restarts at address 0 in the first cycle after rst deasserts.
- INIT timing:
  - write_en is high for exactly 32 consecutive cycles, starting the cycle after the first clean edge.
  - init_done rises in the cycle after write_en for address 31 is presented.
- Latency: request accepted at edge E → write_en / addr / data presented during cycle E+1 → register file written at edge E+2, if uncontested.
- Contested: the loser waits one cycle per older or winning entry. The worst case is 2 cycles in the output stage.
- Throughput: 1 write per cycle total. Both requesters streaming each get 1 write every 2 cycles, alternating.
- A data/address change while valid & !ready is ignored; requesters hold their values until accepted.

## Structure
- Package regfile_pkg:
  - REG_ADDR_W = 5, NUM_REGS = 32, default WORDSIZE = 64.
  - State enum {INIT, RUN}.
  - Requester id enum {REQ_ALU, REQ_MEM}.
- Sub-module wb_slot: one-entry buffer with full flag, addr, data and age counter. It is instantiated twice.
- The arbiter, FSM and output registers live in the top module.

## Test plan
- Reset then idle:
  - write_en high for 32 cycles with addresses 0..31 and data 0.
  - init_done = 1 at cycle 33.
  - Ready signals stay 0 until then.
- RUN, single ALU request (addr 5, data 0xDEAD):
  - Accepted at edge E.
  - write_en = 1, write_addr = 5, write_data = 0xDEAD during cycle E+1.
  - write_en = 0 afterwards.
- Both requesters valid in the same cycle (ALU x3 = 1, mem x4 = 2), pointer = ALU:
  - mem is written first, then ALU on the next cycle.
  - Pointer ends at ALU.
- ALU accepted one cycle before mem, both pending:
  - ALU is written first regardless of pointer.
  - mem_ready stays 0 until its slot empties.
- ALU request with addr 0, data 0xFF: accepted, no write_en pulse, slot stays empty.
- rst asserted while both slots are full in RUN: no buffered write ever appears, and the sweep restarts at address 0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port controller.
// Also holds the oldest-first arbitration rule used by the top.
package regfile_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int NUM_REGS         = 32;
  localparam int DEFAULT_WORDSIZE = 64;
  // Ages saturate; a pending entry never waits more than two cycles.
  localparam int AGE_W            = 2;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef enum logic {
    REQ_ALU,
    REQ_MEM
  } req_id_t;

  // Older entry wins. Equal age means both were accepted together, so the
  // requester opposite the last grant goes first.
  function automatic req_id_t pick_winner(
    input logic [AGE_W-1:0] alu_age,
    input logic [AGE_W-1:0] mem_age,
    input req_id_t          last_grant
  );
    req_id_t winner;
    if (alu_age > mem_age) begin
      winner = REQ_ALU;
    end else if (mem_age > alu_age) begin
      winner = REQ_MEM;
    end else if (last_grant == REQ_ALU) begin
      winner = REQ_MEM;
    end else begin
      winner = REQ_ALU;
    end
    return winner;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requests in, register-file write port out.
// Handshake: a request transfers on a rising edge where valid & ready are both 1;
// ready never looks at valid, and the requester holds addr/data stable until then.
interface regfile_write_arbiter_if #(
  parameter int WORDSIZE = 64
);
  import regfile_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [WORDSIZE-1:0]   alu_data;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_addr;
  logic [WORDSIZE-1:0]   mem_data;

  logic                  init_done;
  logic                  write_en;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [WORDSIZE-1:0]   write_data;

  // Requester / register-file side.
  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  init_done, write_en, write_addr, write_data
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output init_done, write_en, write_addr, write_data
  );

endinterface

// File: rtl/regfile_write_arbiter_wb_slot.sv
// One-entry writeback buffer: full flag, destination, data and a saturating
// age counter measuring cycles since acceptance.
module wb_slot
  import regfile_pkg::*;
#(
  parameter int WORDSIZE = DEFAULT_WORDSIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  grant,
  input  logic [REG_ADDR_W-1:0] in_addr,
  input  logic [WORDSIZE-1:0]   in_data,
  output logic                  full,
  output logic [REG_ADDR_W-1:0] addr,
  output logic [WORDSIZE-1:0]   data,
  output logic [AGE_W-1:0]      age
);

  // A load in the same cycle as a grant is a refill: the new entry wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
      age  <= '0;
    end else if (load) begin
      full <= 1'b1;
      addr <= in_addr;
      data <= in_data;
      age  <= '0;
    end else if (grant) begin
      full <= 1'b0;
      age  <= '0;
    end else if (full && (age != {AGE_W{1'b1}})) begin
      age  <= age + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-fills all registers after reset,
// then arbitrates ALU and load-unit writebacks oldest-first.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int WORDSIZE = DEFAULT_WORDSIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus,
  output state_t                  dbg_state,
  output req_id_t                 dbg_last_grant
);

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] sweep_q, sweep_d;
  logic                  init_done_q;
  req_id_t               last_grant_q;

  logic                  write_en_q;
  logic [REG_ADDR_W-1:0] write_addr_q;
  logic [WORDSIZE-1:0]   write_data_q;

  logic                  alu_full, mem_full;
  logic [REG_ADDR_W-1:0] alu_slot_addr, mem_slot_addr;
  logic [WORDSIZE-1:0]   alu_slot_data, mem_slot_data;
  logic [AGE_W-1:0]      alu_age, mem_age;

  logic grant_alu, grant_mem;
  logic alu_ready, mem_ready;
  logic load_alu, load_mem;

  // Grants depend only on slot contents, so ready never sees valid.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (init_done_q) begin
      if (alu_full && mem_full) begin
        if (pick_winner(alu_age, mem_age, last_grant_q) == REQ_ALU) begin
          grant_alu = 1'b1;
        end else begin
          grant_mem = 1'b1;
        end
      end else if (alu_full) begin
        grant_alu = 1'b1;
      end else if (mem_full) begin
        grant_mem = 1'b1;
      end
    end
  end

  assign alu_ready = init_done_q & (~alu_full | grant_alu);
  assign mem_ready = init_done_q & (~mem_full | grant_mem);

  // Writes to x0 complete the handshake but are dropped here.
  assign load_alu = bus.alu_valid & alu_ready & (bus.alu_addr != '0);
  assign load_mem = bus.mem_valid & mem_ready & (bus.mem_addr != '0);

  wb_slot #(.WORDSIZE(WORDSIZE)) u_alu_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (load_alu),
    .grant   (grant_alu),
    .in_addr (bus.alu_addr),
    .in_data (bus.alu_data),
    .full    (alu_full),
    .addr    (alu_slot_addr),
    .data    (alu_slot_data),
    .age     (alu_age)
  );

  wb_slot #(.WORDSIZE(WORDSIZE)) u_mem_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (load_mem),
    .grant   (grant_mem),
    .in_addr (bus.mem_addr),
    .in_data (bus.mem_data),
    .full    (mem_full),
    .addr    (mem_slot_addr),
    .data    (mem_slot_data),
    .age     (mem_age)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == REG_ADDR_W'(NUM_REGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // init_done trails the state by a cycle so it rises after address 31 is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= (state_q == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_ALU;
    end else if (grant_alu) begin
      last_grant_q <= REQ_ALU;
    end else if (grant_mem) begin
      last_grant_q <= REQ_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else if (state_q == INIT) begin
      write_en_q   <= 1'b1;
      write_addr_q <= sweep_q;
      write_data_q <= '0;
    end else if (grant_alu) begin
      write_en_q   <= 1'b1;
      write_addr_q <= alu_slot_addr;
      write_data_q <= alu_slot_data;
    end else if (grant_mem) begin
      write_en_q   <= 1'b1;
      write_addr_q <= mem_slot_addr;
      write_data_q <= mem_slot_data;
    end else begin
      write_en_q   <= 1'b0;
    end
  end

  assign bus.alu_ready  = alu_ready;
  assign bus.mem_ready  = mem_ready;
  assign bus.init_done  = init_done_q;
  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;

  assign dbg_state      = state_q;
  assign dbg_last_grant = last_grant_q;

endmodule
